// File: rtl/aes_sbox_bist.sv
// Self-checking sweep engine for masked AES S-box instances: drives all 256 inputs as
// Boolean shares over LANES parallel DUTs, recombines their outputs and checks them.
module aes_sbox_bist #(
    parameter int SHARES  = 2,
    parameter int LANES   = 1,
    parameter int LATENCY = 4,
    parameter int RAND_W  = 40
) (
    input  logic                                      ClkxCI,
    input  logic                                      RstxRI,
    input  logic                                      StartxSI,
    input  logic                                      MaskEnxSI,
    input  logic [LANES*(8*(SHARES-1)+RAND_W)-1:0]    RndxDI,
    output logic [8*SHARES*LANES-1:0]                 XxDO,
    output logic [LANES*RAND_W-1:0]                   RndxDO,
    input  logic [8*SHARES*LANES-1:0]                 QxDI,
    output logic                                      BusyxSO,
    output logic                                      DonexSO,
    output logic                                      PassxSO,
    output logic [8:0]                                ErrCntxDO,
    output logic [7:0]                                FirstFailxDO,
    output logic                                      FailValidxSO
);

    localparam int LW    = 8*(SHARES-1) + RAND_W;
    localparam int NSTEP = 256 / LANES;
    localparam int KW    = $clog2(NSTEP);
    localparam int DW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int XW    = 8*SHARES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 (0 maps to 0), followed by the forward affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] b;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        for (int i = 0; i < 8; i++) begin
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
        end
        return b ^ 8'h63;
    endfunction

    logic [1:0]              r_state;
    logic [KW-1:0]           r_k;
    logic [DW-1:0]           r_drain;
    logic                    r_mask_en;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic                    r_fv;
    logic [8:0]              r_err;
    logic [7:0]              r_ff;
    logic [XW*LANES-1:0]     r_x;
    logic [LANES*RAND_W-1:0] r_rnd;
    logic                    r_cur_vld;
    logic [KW-1:0]           r_cur_k;
    logic                    r_dly_vld [LATENCY];
    logic [KW-1:0]           r_dly_k   [LATENCY];

    logic                    w_start;
    logic                    w_last_feed;
    logic                    w_issue;
    logic [KW-1:0]           w_issue_k;
    logic                    w_men;
    logic                    w_cmp_vld;
    logic [KW-1:0]           w_cmp_k;
    logic [XW*LANES-1:0]     w_x_gen;
    logic [LANES*RAND_W-1:0] w_rnd_gen;
    logic [LANES-1:0]        w_fail;
    logic [3:0]              w_nfail;
    logic [7:0]              w_ff_x;
    logic                    w_any;
    logic [9:0]              w_err_sum;
    logic [8:0]              w_err_next;

    assign w_start     = StartxSI && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_feed = (r_state == S_FEED) && (r_k == KW'(NSTEP-1));
    assign w_issue     = w_start || ((r_state == S_FEED) && !w_last_feed);
    assign w_issue_k   = (r_state == S_FEED) ? r_k + KW'(1) : '0;
    // The mask enable is latched at start; on the start cycle itself it comes straight from the pin.
    assign w_men       = (r_state == S_FEED) ? r_mask_en : MaskEnxSI;
    assign w_cmp_vld   = r_dly_vld[LATENCY-1];
    assign w_cmp_k     = r_dly_k[LATENCY-1];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LW-1:0] w_slice;
            logic [7:0]    w_xv;
            logic [7:0]    w_xc;
            logic [7:0]    w_rec;
            logic [XW-1:0] w_xs;

            assign w_slice = RndxDI[gi*LW +: LW];
            assign w_xv    = 8'(int'(w_issue_k)*LANES + gi);
            assign w_xc    = 8'(int'(w_cmp_k)*LANES + gi);

            always_comb begin
                w_xs       = '0;
                w_xs[7:0]  = w_xv;
                for (int s = 1; s < SHARES; s++) begin
                    if (w_men) begin
                        w_xs[s*8 +: 8] = w_slice[(s-1)*8 +: 8];
                        w_xs[7:0]      = w_xs[7:0] ^ w_slice[(s-1)*8 +: 8];
                    end
                end
            end

            always_comb begin
                w_rec = '0;
                for (int s = 0; s < SHARES; s++) begin
                    w_rec = w_rec ^ QxDI[(gi*SHARES+s)*8 +: 8];
                end
            end

            assign w_x_gen[gi*XW +: XW]           = w_xs;
            assign w_rnd_gen[gi*RAND_W +: RAND_W] = w_men ? w_slice[LW-1 -: RAND_W] : '0;
            assign w_fail[gi]                     = w_cmp_vld && (w_rec != sbox(w_xc));
        end
    endgenerate

    // Descending scan so the lowest failing lane is the one captured.
    always_comb begin
        w_nfail = '0;
        w_ff_x  = '0;
        w_any   = 1'b0;
        for (int l = LANES-1; l >= 0; l--) begin
            if (w_fail[l]) begin
                w_nfail = w_nfail + 4'd1;
                w_ff_x  = 8'(int'(w_cmp_k)*LANES + l);
                w_any   = 1'b1;
            end
        end
        w_err_sum  = {1'b0, r_err} + {6'd0, w_nfail};
        w_err_next = (w_err_sum > 10'd256) ? 9'd256 : w_err_sum[8:0];
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_drain   <= '0;
            r_mask_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fv      <= 1'b0;
            r_err     <= '0;
            r_ff      <= '0;
            r_x       <= '0;
            r_rnd     <= '0;
            r_cur_vld <= 1'b0;
            r_cur_k   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dly_vld[i] <= 1'b0;
                r_dly_k[i]   <= '0;
            end
        end else begin
            r_x          <= w_issue ? w_x_gen : '0;
            r_rnd        <= w_issue ? w_rnd_gen : '0;
            r_cur_vld    <= w_issue;
            r_cur_k      <= w_issue_k;
            r_dly_vld[0] <= r_cur_vld;
            r_dly_k[0]   <= r_cur_k;
            for (int i = 1; i < LATENCY; i++) begin
                r_dly_vld[i] <= r_dly_vld[i-1];
                r_dly_k[i]   <= r_dly_k[i-1];
            end
            r_err <= w_err_next;
            if (w_any && !r_fv) begin
                r_fv <= 1'b1;
                r_ff <= w_ff_x;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (StartxSI) begin
                        r_state   <= S_FEED;
                        r_k       <= '0;
                        r_mask_en <= MaskEnxSI;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_err     <= '0;
                        r_fv      <= 1'b0;
                    end
                end
                S_FEED: begin
                    if (w_last_feed) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_k <= w_issue_k;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DW'(LATENCY-1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 9'd0);
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign XxDO         = r_x;
    assign RndxDO       = r_rnd;
    assign BusyxSO      = r_busy;
    assign DonexSO      = r_done;
    assign PassxSO      = r_pass;
    assign ErrCntxDO    = r_err;
    assign FirstFailxDO = r_ff;
    assign FailValidxSO = r_fv;

endmodule

// File: tb/tb_aes_sbox_bist.sv
// Bench for aes_sbox_bist: a 3-share single-lane instance with a re-masking S-box model,
// and a 4-lane instance whose DUT model always returns zero.
module tb_aes_sbox_bist;

    localparam int LAT_A = 4;
    localparam int LAT_B = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic         start_a, men_a, busy_a, done_a, pass_a, fv_a;
    logic [55:0]  rnd_a;
    logic [23:0]  xa, qa;
    logic [39:0]  ra;
    logic [8:0]   err_a;
    logic [7:0]   ff_a;

    logic         start_b, men_b, busy_b, done_b, pass_b, fv_b;
    logic [191:0] rnd_b;
    logic [63:0]  xb, qb;
    logic [159:0] rb;
    logic [8:0]   err_b;
    logic [7:0]   ff_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [256];
    int exp_x_q[$];
    int exp_err_q[$];
    int exp_ff_q[$];
    int exp_fv_q[$];

    aes_sbox_bist #(.SHARES(3), .LANES(1), .LATENCY(LAT_A), .RAND_W(40)) u_dut_a (
        .ClkxCI(clk), .RstxRI(rst), .StartxSI(start_a), .MaskEnxSI(men_a),
        .RndxDI(rnd_a), .XxDO(xa), .RndxDO(ra), .QxDI(qa),
        .BusyxSO(busy_a), .DonexSO(done_a), .PassxSO(pass_a),
        .ErrCntxDO(err_a), .FirstFailxDO(ff_a), .FailValidxSO(fv_a)
    );

    aes_sbox_bist #(.SHARES(2), .LANES(4), .LATENCY(LAT_B), .RAND_W(40)) u_dut_b (
        .ClkxCI(clk), .RstxRI(rst), .StartxSI(start_b), .MaskEnxSI(men_b),
        .RndxDI(rnd_b), .XxDO(xb), .RndxDO(rb), .QxDI(qb),
        .BusyxSO(busy_b), .DonexSO(done_b), .PassxSO(pass_b),
        .ErrCntxDO(err_b), .FirstFailxDO(ff_b), .FailValidxSO(fv_b)
    );

    // Masked S-box model: recombine, look up, optionally corrupt 0x53, re-share with fresh masks.
    bit corrupt_a = 1'b0;
    logic [23:0] qa_pipe [LAT_A];
    always @(posedge clk) begin : m_a
        logic [7:0] xv, y, r1, r2;
        xv = xa[7:0] ^ xa[15:8] ^ xa[23:16];
        y  = sb[xv];
        if (corrupt_a && xv == 8'h53) y = y ^ 8'h01;
        r1 = 8'($urandom());
        r2 = 8'($urandom());
        qa_pipe[0] <= {r2, r1, y ^ r1 ^ r2};
        for (int i = 1; i < LAT_A; i++) qa_pipe[i] <= qa_pipe[i-1];
    end
    assign qa = qa_pipe[LAT_A-1];
    assign qb = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference table from the log/antilog walk over generator 3, independent of inversion by powering.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic new_rnd_a();
        rnd_a = 56'({$urandom(), $urandom()});
    endtask

    task automatic new_rnd_b();
        for (int i = 0; i < 6; i++) rnd_b[i*32 +: 32] = $urandom();
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_a(input string name, input bit men, input bit corrupt,
                         input bit pulse_feed, input int abort_at);
        int t, n, ff, fv;
        corrupt_a = corrupt;
        exp_x_q.delete();
        n = 0; ff = 0; fv = 0;
        for (int x = 0; x < 256; x++) begin
            exp_x_q.push_back(x);
            if (corrupt && x == 8'h53) begin
                if (fv == 0) ff = x;
                fv = 1;
                n++;
            end
        end
        exp_err_q.push_back(n);
        exp_ff_q.push_back(ff);
        exp_fv_q.push_back(fv);

        @(negedge clk);
        men_a = men; start_a = 1'b1; t = cyc;
        new_rnd_a();
        step();
        men_a = ~men;
        for (int i = 0; i < 400; i++) begin
            start_a = 1'b0;
            if (cyc == t + 1) begin
                chk({name, "_busy_rise"}, 64'(busy_a), 64'(1));
                chk({name, "_done_clr"}, 64'(done_a), 64'(0));
                chk({name, "_err_clr"}, 64'(err_a), 64'(0));
                chk({name, "_fv_clr"}, 64'(fv_a), 64'(0));
            end
            if (cyc <= t + 256) begin
                chk({name, "_feed_x"}, 64'(xa[7:0] ^ xa[15:8] ^ xa[23:16]), 64'(exp_x_q.pop_front()));
                if (men) begin
                    chk({name, "_mask"}, 64'({ra, xa[23:8]}), 64'({rnd_a[55:16], rnd_a[15:0]}));
                end else begin
                    chk({name, "_nomask"}, 64'({ra, xa[23:8]}), 64'(0));
                end
            end else if (cyc <= t + 256 + LAT_A) begin
                chk({name, "_drain_zero"}, 64'({ra, xa}), 64'(0));
            end
            if (abort_at > 0 && cyc == t + abort_at) begin
                rst = 1'b1;
                step();
                chk({name, "_rst_outs"}, 64'({busy_a, done_a, pass_a, fv_a, err_a, ff_a}), 64'(0));
                chk({name, "_rst_data"}, 64'({ra, xa}), 64'(0));
                rst = 1'b0;
                exp_x_q.delete();
                void'(exp_err_q.pop_front());
                void'(exp_ff_q.pop_front());
                void'(exp_fv_q.pop_front());
                $display("run %s: aborted by reset at cycle %0d", name, cyc - 1);
                return;
            end
            if (pulse_feed && cyc == t + 50) start_a = 1'b1;
            if (done_a) break;
            new_rnd_a();
            step();
        end
        chk({name, "_done_cycle"}, 64'(cyc), 64'(t + 256 + LAT_A + 1));
        chk({name, "_busy_fall"}, 64'(busy_a), 64'(0));
        n  = exp_err_q.pop_front();
        ff = exp_ff_q.pop_front();
        fv = exp_fv_q.pop_front();
        chk({name, "_errcnt"}, 64'(err_a), 64'(n));
        chk({name, "_pass"}, 64'(pass_a), 64'(n == 0));
        chk({name, "_fvalid"}, 64'(fv_a), 64'(fv));
        if (fv != 0) chk({name, "_firstfail"}, 64'(ff_a), 64'(ff));
        $display("run %s: err=%0d first=%02h valid=%0b pass=%0b done_cycle=%0d",
                 name, err_a, ff_a, fv_a, pass_a, cyc - t);
    endtask

    task automatic run_b();
        int t, n, ff, fv;
        exp_x_q.delete();
        n = 0; ff = 0; fv = 0;
        for (int x = 0; x < 256; x++) begin
            exp_x_q.push_back(x);
            if (sb[x] != 8'h00) begin
                if (fv == 0) ff = x;
                fv = 1;
                n++;
            end
        end
        exp_err_q.push_back(n);
        exp_ff_q.push_back(ff);
        exp_fv_q.push_back(fv);

        @(negedge clk);
        men_b = 1'b1; start_b = 1'b1; t = cyc;
        new_rnd_b();
        step();
        start_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cyc <= t + 64) begin
                for (int l = 0; l < 4; l++) begin
                    chk("b_feed_x", 64'(xb[l*16 +: 8] ^ xb[l*16+8 +: 8]), 64'(exp_x_q.pop_front()));
                end
            end
            if (done_b) break;
            new_rnd_b();
            step();
        end
        chk("b_done_cycle", 64'(cyc), 64'(t + 64 + LAT_B + 1));
        n  = exp_err_q.pop_front();
        ff = exp_ff_q.pop_front();
        fv = exp_fv_q.pop_front();
        chk("b_errcnt", 64'(err_b), 64'(n));
        chk("b_pass", 64'(pass_b), 64'(n == 0));
        chk("b_fvalid", 64'(fv_b), 64'(fv));
        chk("b_firstfail", 64'(ff_b), 64'(ff));
        $display("run lanes4: err=%0d first=%02h valid=%0b pass=%0b done_cycle=%0d",
                 err_b, ff_b, fv_b, pass_b, cyc - t);
    endtask

    initial begin
        build_sbox();
        rst = 1'b1;
        start_a = 1'b0; men_a = 1'b0; rnd_a = '0;
        start_b = 1'b0; men_b = 1'b0; rnd_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("reset_a_outs", 64'({busy_a, done_a, pass_a, fv_a, err_a, ff_a}), 64'(0));
        chk("reset_a_data", 64'({ra, xa}), 64'(0));
        chk("reset_b_outs", 64'({busy_b, done_b, pass_b, fv_b, err_b, ff_b}), 64'(0));

        run_a("nomask", 1'b0, 1'b0, 1'b0, 0);
        run_a("masked", 1'b1, 1'b0, 1'b0, 0);
        run_a("corrupt53", 1'b1, 1'b1, 1'b0, 0);
        run_a("restart_pulse", 1'b1, 1'b0, 1'b1, 0);
        run_a("abort", 1'b0, 1'b0, 1'b0, 100);
        run_a("after_abort", 1'b1, 1'b0, 1'b0, 0);
        run_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
